io_port_unit: RTL and testbench
===============================

IO_PORT_UNIT -- requirements
Module: io_port_unit

Interface
REQ-001 Parameter N_OUT, default 3: number of 32-bit output ports (1..8).
REQ-002 Parameter N_IN, default 2: number of input ports (1..8).
REQ-003 Parameter IN_W, default 5: width of each input port (1..32).
REQ-004 Parameter DIGITS, default 2: decimal digits displayed per output port (1..9).
REQ-005 clock  in  1  single system clock; all state updates on rising edge.
REQ-006 resetn  in  1  synchronous active-low reset.
REQ-007 wr_en  in  1  store strobe from MEM stage.
REQ-008 rd_en  in  1  load strobe from MEM stage.
REQ-009 addr  in  32  byte address from ALU result.
REQ-010 wdata  in  32  store data.
REQ-011 hold  in  1  high = freeze display refresh.
REQ-012 in_port  in  N_IN*IN_W  raw asynchronous inputs (switches); port k at bits [k*IN_W +: IN_W].
REQ-013 rdata  out  32  registered load data.
REQ-014 out_port  out  N_OUT*32  output registers; port k at bits [k*32 +: 32].
REQ-015 bcd  out  N_OUT*DIGITS*4  packed BCD digits; port k at bits [k*DIGITS*4 +: DIGITS*4], least-significant digit lowest.
REQ-016 bcd_valid  out  1  high once every port has been converted at least once since reset.

Function
REQ-017 I/O select: addr[31:8]==0 and addr[7]==1; index = addr[6:2]; addr[1:0] ignored.
REQ-018 wr_en with I/O select and index < N_OUT SHALL load wdata into out_port[index] at the next edge; other indices/addresses are ignored.
REQ-019 Each in_port bit SHALL pass a 2-flop synchronizer; reads return synchronized values only.
REQ-020 rd_en with I/O select SHALL register rdata = zero-extended sync in_port[index] at the next edge (1-cycle latency); index >= N_IN or no I/O select gives rdata = 0; rdata holds when rd_en is low.
REQ-021 wr_en and rd_en in the same cycle SHALL both be performed independently.
REQ-022 Converter FSM states IDLE, LOAD, SHIFT, STORE; one port converted at a time, round-robin index p = 0..N_OUT-1, wrapping to 0.
REQ-023 IDLE -> LOAD when hold is low; remains in IDLE while hold is high.
REQ-024 LOAD (1 cycle) SHALL snapshot min(out_port[p], 10^DIGITS-1) (saturation) into the shift register and clear the BCD scratch.
REQ-025 SHIFT SHALL run exactly 32 cycles of double-dabble (add 3 to any nibble >= 5, then shift left by 1).
REQ-026 STORE (1 cycle) SHALL write the scratch digits into bcd[p], advance p, and return to IDLE; a full port conversion therefore takes 35 cycles.
REQ-027 A write to out_port[p] during LOAD or SHIFT SHALL NOT alter the conversion in progress; the new value appears on the next visit to p.
REQ-028 Asserting hold mid-conversion SHALL let the conversion finish through STORE, then stop in IDLE.
REQ-029 bcd_valid SHALL rise on the STORE of port N_OUT-1 in the first round after reset and stay high until reset.
REQ-030 With hold low, a write SHALL appear on bcd within 2*N_OUT*35 cycles.

Reset
REQ-031 resetn low at an edge SHALL clear out_port, bcd, rdata, the synchronizers, bcd_valid and p to 0 and force IDLE, aborting any conversion; no partial STORE takes place.
REQ-032 In the cycle after resetn returns high, the FSM SHALL leave IDLE if hold is low.

Verification
REQ-033 Reset, then write 0x2A to addr 0x80 and 0x07 to 0x84 -> out_port0=42, out_port1=7; after <=210 cycles bcd port0=4,2 and port1=0,7; bcd_valid=1 after the first full round.
REQ-034 Write 12345 to addr 0x88 with DIGITS=2 -> out_port2=12345, bcd port2 saturates to 9,9.
REQ-035 in_port0=5'b10110, then rd_en on addr 0x80 three cycles later -> rdata=0x16 one cycle after rd_en; rd_en on 0x90 -> rdata=0.
REQ-036 Write port0=99 and wait for its LOAD, then write port0=3 during SHIFT -> bcd0 shows 9,9 first and 0,3 after the next visit.
REQ-037 Assert hold mid-SHIFT on port1 -> the port1 STORE completes and bcd stays frozen while further writes occur; release hold -> updates resume.
REQ-038 Assert resetn low mid-SHIFT -> all outputs 0 the next cycle and bcd_valid=0.

Source files
------------

// File: rtl/io_port_unit.sv
`default_nettype none
// ============================================================================
// Module      : io_port_unit
// Description : Memory-mapped I/O port block. It holds N_OUT 32-bit output
//               registers and N_IN synchronized input ports, and has a
//               round-robin double-dabble converter that keeps a decimal BCD
//               image of every output port for display.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_unit #(
  parameter int N_OUT  = 3,
  parameter int N_IN   = 2,
  parameter int IN_W   = 5,
  parameter int DIGITS = 2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wdata,
  input  logic                         hold,
  input  logic [N_IN*IN_W-1:0]         in_port,
  output logic [31:0]                  rdata,
  output logic [N_OUT*32-1:0]          out_port,
  output logic [N_OUT*DIGITS*4-1:0]    bcd,
  output logic                         bcd_valid
);

  localparam int              PW         = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int              BW         = DIGITS * 4;
  localparam logic [31:0]     C_MAX_VAL  = 32'(10**DIGITS - 1);
  localparam logic [PW-1:0]   C_LAST_P   = PW'(N_OUT - 1);
  localparam logic [4:0]      C_LAST_CNT = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_STORE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Address decode: the I/O window is 0x80..0xFF, one word per port.
  // --------------------------------------------------------------------------
  logic       io_sel;
  logic [4:0] io_idx;
  logic       unused_addr_lsb;

  assign io_sel          = (addr[31:8] == 24'd0) && addr[7];
  assign io_idx          = addr[6:2];
  assign unused_addr_lsb = ^addr[1:0];

  // --------------------------------------------------------------------------
  // Bus-side state
  // --------------------------------------------------------------------------
  logic [31:0]            out_q   [N_OUT];
  logic [31:0]            out_d   [N_OUT];
  logic [N_IN*IN_W-1:0]   sync1_q, sync1_d;
  logic [N_IN*IN_W-1:0]   sync2_q, sync2_d;
  logic [31:0]            rdata_q, rdata_d;

  // Next-state for output registers, input synchronizers and load data.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      out_d[k] = out_q[k];
      if (wr_en && io_sel && (io_idx == 5'(k))) begin
        out_d[k] = wdata;
      end
    end
    sync1_d = in_port;
    sync2_d = sync1_q;
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = 32'd0;
      if (io_sel) begin
        for (int k = 0; k < N_IN; k++) begin
          if (io_idx == 5'(k)) begin
            rdata_d = 32'(sync2_q[k*IN_W +: IN_W]);
          end
        end
      end
    end
  end

  // Bus-side registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < N_OUT; k++) begin
        out_q[k] <= 32'd0;
      end
      sync1_q <= '0;
      sync2_q <= '0;
      rdata_q <= 32'd0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        out_q[k] <= out_d[k];
      end
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rdata_q <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // BCD converter
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        shift_q, shift_d;
  logic [BW-1:0]      scratch_q, scratch_d;
  logic [BW-1:0]      bcd_q [N_OUT];
  logic [BW-1:0]      bcd_d [N_OUT];
  logic               bcd_valid_q, bcd_valid_d;

  logic [31:0]        cur_val;
  logic [31:0]        sat_val;
  logic [BW-1:0]      dd_adj;
  logic               unused_dd_msb;

  // Select the port being converted and clamp it to what DIGITS can show.
  always_comb begin
    cur_val = 32'd0;
    for (int k = 0; k < N_OUT; k++) begin
      if (p_q == PW'(k)) begin
        cur_val = out_q[k];
      end
    end
    sat_val = (cur_val > C_MAX_VAL) ? C_MAX_VAL : cur_val;
  end

  // Double-dabble correction: add 3 to every digit of 5 or more.
  always_comb begin
    dd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[d*4 +: 4] >= 4'd5) begin
        dd_adj[d*4 +: 4] = scratch_q[d*4 +: 4] + 4'd3;
      end else begin
        dd_adj[d*4 +: 4] = scratch_q[d*4 +: 4];
      end
    end
  end

  // The saturated value always fits in DIGITS digits, so the top bit
  // shifted out of the scratch is always zero.
  assign unused_dd_msb = dd_adj[BW-1];

  // Converter next-state and datapath.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    scratch_d   = scratch_q;
    bcd_valid_d = bcd_valid_q;
    for (int k = 0; k < N_OUT; k++) begin
      bcd_d[k] = bcd_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (!hold) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d   = sat_val;
        scratch_d = '0;
        cnt_d     = 5'd0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        scratch_d = {dd_adj[BW-2:0], shift_q[31]};
        shift_d   = {shift_q[30:0], 1'b0};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == C_LAST_CNT) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        for (int k = 0; k < N_OUT; k++) begin
          if (p_q == PW'(k)) begin
            bcd_d[k] = scratch_q;
          end
        end
        if (p_q == C_LAST_P) begin
          p_d         = '0;
          bcd_valid_d = 1'b1;
        end else begin
          p_d = p_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Converter registers; reset aborts any conversion without a STORE.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      cnt_q       <= 5'd0;
      shift_q     <= 32'd0;
      scratch_q   <= '0;
      bcd_valid_q <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        bcd_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      scratch_q   <= scratch_d;
      bcd_valid_q <= bcd_valid_d;
      for (int k = 0; k < N_OUT; k++) begin
        bcd_q[k] <= bcd_d[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < N_OUT; k++) begin : g_out_ports
      assign out_port[k*32 +: 32] = out_q[k];
      assign bcd[k*BW +: BW]      = bcd_q[k];
    end
  endgenerate

  assign rdata     = rdata_q;
  assign bcd_valid = bcd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_io_port_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_unit
// Description : Self-checking bench for io_port_unit: a behavioural model
//               compared every cycle, plus hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_unit;

  localparam int N_OUT  = 3;
  localparam int N_IN   = 2;
  localparam int IN_W   = 5;
  localparam int DIGITS = 2;
  localparam int BW     = DIGITS * 4;
  localparam int MAXV   = 10**DIGITS - 1;
  localparam int BUDGET = 400;

  logic                       clock = 1'b0;
  logic                       resetn, wr_en, rd_en, hold;
  logic [31:0]                addr, wdata;
  logic [N_IN*IN_W-1:0]       in_port;
  logic [31:0]                rdata;
  logic [N_OUT*32-1:0]        out_port;
  logic [N_OUT*BW-1:0]        bcd;
  logic                       bcd_valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  io_port_unit #(.N_OUT(N_OUT), .N_IN(N_IN), .IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clock(clock), .resetn(resetn), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .hold(hold), .in_port(in_port),
    .rdata(rdata), .out_port(out_port), .bcd(bcd), .bcd_valid(bcd_valid)
  );

  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [31:0]      m_out   [N_OUT];
  logic [BW-1:0]    m_bcd   [N_OUT];
  logic [IN_W-1:0]  m_s1    [N_IN];
  logic [IN_W-1:0]  m_s2    [N_IN];
  logic [31:0]      m_rdata;
  logic [31:0]      m_snap;
  bit               m_valid;
  bit               m_busy;
  int               m_t;
  int               m_p;

  function automatic logic [BW-1:0] to_bcd(input logic [31:0] v);
    logic [BW-1:0] r;
    int unsigned   x;
    x = (v > 32'(MAXV)) ? MAXV : v;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // A conversion is a 35-edge frame starting at the edge that leaves idle:
  // the value is captured at frame edge 1 and published at frame edge 34.
  always @(posedge clock) begin
    int  idx;
    bit  sel;
    idx = int'(addr[6:2]);
    sel = (addr[31:8] == 24'd0) && addr[7];
    if (!resetn) begin
      for (int k = 0; k < N_OUT; k++) begin
        m_out[k] = '0;
        m_bcd[k] = '0;
      end
      for (int k = 0; k < N_IN; k++) begin
        m_s1[k] = '0;
        m_s2[k] = '0;
      end
      m_rdata = '0; m_snap = '0; m_valid = 0; m_busy = 0; m_t = 0; m_p = 0;
    end else begin
      if (!m_busy) begin
        if (!hold) begin
          m_busy = 1; m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t == 1) m_snap = m_out[m_p];
        if (m_t == 34) begin
          m_bcd[m_p] = to_bcd(m_snap);
          if (m_p == N_OUT - 1) begin
            m_valid = 1; m_p = 0;
          end else begin
            m_p++;
          end
          m_busy = 0;
        end
      end
      if (rd_en) begin
        m_rdata = '0;
        if (sel && idx < N_IN) m_rdata = 32'(m_s2[idx]);
      end
      for (int k = 0; k < N_IN; k++) begin
        m_s2[k] = m_s1[k];
        m_s1[k] = in_port[k*IN_W +: IN_W];
      end
      if (wr_en && sel && idx < N_OUT) m_out[idx] = wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("model_rdata", rdata, m_rdata);
      chk("model_bcd_valid", 32'(bcd_valid), 32'(m_valid));
      for (int k = 0; k < N_OUT; k++) begin
        chk("model_out_port", out_port[k*32 +: 32], m_out[k]);
        chk("model_bcd", 32'(bcd[k*BW +: BW]), 32'(m_bcd[k]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input logic [31:0] a);
    rd_en = 1'b1; addr = a;
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  int b;

  initial begin
    resetn = 1'b0; hold = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wdata = '0; in_port = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    cmp_en = 1'b1;
    chk("reset_out_port0", out_port[31:0], 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_bcd_valid", 32'(bcd_valid), 32'd0);

    // Basic writes and conversion
    resetn = 1'b1;
    do_wr(32'h80, 32'h2A);
    do_wr(32'h84, 32'h07);
    repeat (210) @(negedge clock);
    chk("lit_out0_42", out_port[31:0], 32'd42);
    chk("lit_out1_7", out_port[63:32], 32'd7);
    chk("lit_bcd0_42", 32'(bcd[7:0]), 32'h42);
    chk("lit_bcd1_07", 32'(bcd[15:8]), 32'h07);
    chk("lit_bcd_valid", 32'(bcd_valid), 32'd1);

    // Saturation
    do_wr(32'h88, 32'd12345);
    repeat (210) @(negedge clock);
    chk("lit_out2_12345", out_port[95:64], 32'd12345);
    chk("lit_bcd2_sat", 32'(bcd[23:16]), 32'h99);

    // Ignored writes
    do_wr(32'h8C, 32'hDEAD);
    do_wr(32'h100, 32'd5);
    do_wr(32'h180, 32'd5);
    do_wr(32'hFC, 32'd5);
    chk("lit_ignored_out0", out_port[31:0], 32'd42);
    chk("lit_ignored_out2", out_port[95:64], 32'd12345);

    // Synchronized reads
    in_port = {5'b00011, 5'b10110};
    repeat (3) @(negedge clock);
    do_rd(32'h80);
    chk("lit_rd_port0", rdata, 32'h16);
    do_rd(32'h84);
    chk("lit_rd_port1", rdata, 32'h03);
    do_rd(32'h83);
    chk("lit_rd_lsb_ignored", rdata, 32'h16);
    @(negedge clock);
    chk("lit_rd_hold", rdata, 32'h16);
    do_rd(32'h90);
    chk("lit_rd_bad_index", rdata, 32'd0);
    do_rd(32'h180);
    chk("lit_rd_no_sel", rdata, 32'd0);
    in_port = {5'b00011, 5'b01001};
    rd_en = 1'b1; addr = 32'h80;
    @(negedge clock);
    chk("lit_sync_lat1", rdata, 32'h16);
    @(negedge clock);
    chk("lit_sync_lat2", rdata, 32'h16);
    @(negedge clock);
    chk("lit_sync_lat3", rdata, 32'h09);
    rd_en = 1'b0;

    // Simultaneous load and store
    wr_en = 1'b1; rd_en = 1'b1; addr = 32'h84; wdata = 32'd8;
    @(negedge clock);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("lit_rw_rdata", rdata, 32'h03);
    chk("lit_rw_out1", out_port[63:32], 32'd8);

    // Write during conversion does not disturb it
    b = 0;
    while (!(m_busy && m_p == 1) && b < BUDGET) begin @(negedge clock); b++; end
    chk("wait_port1_busy", 32'(b < BUDGET), 32'd1);
    do_wr(32'h80, 32'd99);
    b = 0;
    while (!(m_busy && m_p == 0 && m_t == 1) && b < BUDGET) begin @(negedge clock); b++; end
    chk("wait_port0_shift", 32'(b < BUDGET), 32'd1);
    do_wr(32'h80, 32'd3);
    b = 0;
    while (!(!m_busy && m_p == 1) && b < BUDGET) begin @(negedge clock); b++; end
    chk("wait_port0_store", 32'(b < BUDGET), 32'd1);
    chk("lit_bcd0_99_first", 32'(bcd[7:0]), 32'h99);
    b = 0;
    while (!(m_busy && m_p == 0) && b < BUDGET) begin @(negedge clock); b++; end
    b = 0;
    while (!(!m_busy && m_p == 1) && b < BUDGET) begin @(negedge clock); b++; end
    chk("wait_port0_store2", 32'(b < BUDGET), 32'd1);
    chk("lit_bcd0_03_next", 32'(bcd[7:0]), 32'h03);

    // Hold mid-conversion
    b = 0;
    while (!(m_busy && m_p == 1 && m_t == 10) && b < BUDGET) begin @(negedge clock); b++; end
    chk("wait_port1_shift", 32'(b < BUDGET), 32'd1);
    hold = 1'b1;
    b = 0;
    while (m_busy && b < BUDGET) begin @(negedge clock); b++; end
    chk("lit_hold_store_bcd1", 32'(bcd[15:8]), 32'h08);
    do_wr(32'h84, 32'd55);
    do_wr(32'h88, 32'd66);
    repeat (150) @(negedge clock);
    chk("lit_frozen_bcd1", 32'(bcd[15:8]), 32'h08);
    chk("lit_frozen_bcd2", 32'(bcd[23:16]), 32'h99);
    chk("lit_frozen_out1", out_port[63:32], 32'd55);
    hold = 1'b0;
    repeat (210) @(negedge clock);
    chk("lit_resume_bcd1", 32'(bcd[15:8]), 32'h55);
    chk("lit_resume_bcd2", 32'(bcd[23:16]), 32'h66);

    // Reset mid-conversion
    b = 0;
    while (!(m_busy && m_t == 15) && b < BUDGET) begin @(negedge clock); b++; end
    chk("wait_mid_shift", 32'(b < BUDGET), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    chk("lit_rst_out_lo", out_port[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    chk("lit_rst_out2", out_port[95:64], 32'd0);
    chk("lit_rst_bcd", 32'(bcd), 32'd0);
    chk("lit_rst_rdata", rdata, 32'd0);
    chk("lit_rst_valid", 32'(bcd_valid), 32'd0);

    // Conversion restarts right after reset: 35 edges to the first STORE
    resetn = 1'b1;
    do_wr(32'h80, 32'd42);
    repeat (33) @(negedge clock);
    chk("lit_restart_before", 32'(bcd[7:0]), 32'h00);
    @(negedge clock);
    chk("lit_restart_store", 32'(bcd[7:0]), 32'h42);
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
